mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 35 +++
 rtl/mem_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and limits for the memory arbiter: FSM state encoding,
// channel/latency bounds and the performance-counter helper.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  localparam int MAX_CH      = 8;
  localparam int MAX_LATENCY = 15;
  localparam int PERF_CNT_W  = 16;

  // Saturating increment so a busy channel's counter sticks at all-ones
  function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] v);
    return (v == {PERF_CNT_W{1'b1}}) ? v : v + PERF_CNT_W'(1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the search starts one past last_grant
// and wraps, returning a one-hot grant and its encoded index.
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_CH = 2,
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  last_grant,
  output logic [NUM_CH-1:0] grant,
  output logic [IDX_W-1:0]  grant_idx
);

  logic [IDX_W-1:0] pos_s;
  logic             hit_s;
  logic             found_s;

  // First requester at or after last_grant+1 (mod NUM_CH) wins
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    pos_s     = '0;
    hit_s     = 1'b0;
    found_s   = 1'b0;
    for (int i = 1; i <= NUM_CH; i++) begin
      pos_s          = IDX_W'((int'(last_grant) + i) % NUM_CH);
      hit_s          = req[pos_s] & ~found_s;
      grant[pos_s]   = grant[pos_s] | hit_s;
      grant_idx      = hit_s ? pos_s : grant_idx;
      found_s        = found_s | hit_s;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter of NUM_CH request channels onto one memory port.
// Optional per-channel grant counters are enabled with MEM_ARB_PERF_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        req_valid,
  input  logic [NUM_CH-1:0]        req_we,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr,
  input  logic [NUM_CH*DATA_W-1:0] req_wdata,
  output logic [NUM_CH-1:0]        req_ready,
  output logic [NUM_CH-1:0]        resp_valid,
  output logic [DATA_W-1:0]        resp_rdata,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic                     mem_read,
  output logic                     mem_write,
  input  logic [DATA_W-1:0]        mem_rdata
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [NUM_CH*PERF_CNT_W-1:0] perf_grants
`endif
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = $clog2(LATENCY + 1);

  arb_state_e        state_r;
  arb_state_e        state_nxt_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [IDX_W-1:0]  last_grant_r;
  logic [NUM_CH-1:0] cur_oh_r;
  logic              cur_we_r;
  logic [NUM_CH-1:0] gnt_oh_s;
  logic [IDX_W-1:0]  gnt_idx_s;
  logic              accept_s;
  logic              finish_s;
  logic              sel_we_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_wdata_s;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_rr (
    .req        (req_valid),
    .last_grant (last_grant_r),
    .grant      (gnt_oh_s),
    .grant_idx  (gnt_idx_s)
  );

  assign sel_we_s    = req_we[gnt_idx_s];
  assign sel_addr_s  = req_addr[gnt_idx_s*ADDR_W +: ADDR_W];
  assign sel_wdata_s = req_wdata[gnt_idx_s*DATA_W +: DATA_W];

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state plus the combinational accept pulse; held off while in reset
  always_comb begin
    state_nxt_s = state_r;
    req_ready   = '0;
    accept_s    = 1'b0;
    finish_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (rst && (|req_valid)) begin
          req_ready   = gnt_oh_s;
          accept_s    = 1'b1;
          state_nxt_s = ACCESS;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACCESS: begin
        if (cnt_r <= CNT_W'(1)) begin
          finish_s    = 1'b1;
          state_nxt_s = RESP;
        end else begin
          state_nxt_s = ACCESS;
        end
      end
      RESP:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Transaction datapath: latch on accept, strobe for LATENCY cycles, respond
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r        <= '0;
      last_grant_r <= IDX_W'(NUM_CH - 1);
      cur_oh_r     <= '0;
      cur_we_r     <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      resp_valid   <= '0;
      resp_rdata   <= '0;
    end else begin
      resp_valid <= '0;
      if (accept_s) begin
        last_grant_r <= gnt_idx_s;
        cur_oh_r     <= gnt_oh_s;
        cur_we_r     <= sel_we_s;
        mem_addr     <= sel_addr_s;
        mem_wdata    <= sel_wdata_s;
        mem_read     <= ~sel_we_s;
        mem_write    <= sel_we_s;
        cnt_r        <= CNT_W'(LATENCY);
      end else if (state_r == ACCESS) begin
        cnt_r <= cnt_r - CNT_W'(1);
        if (finish_s) begin
          mem_read   <= 1'b0;
          mem_write  <= 1'b0;
          resp_valid <= cur_oh_r;
          resp_rdata <= cur_we_r ? '0 : mem_rdata;
        end else begin
          mem_read   <= mem_read;
          mem_write  <= mem_write;
        end
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

`ifdef MEM_ARB_PERF_EN
  for (genvar g = 0; g < NUM_CH; g++) begin : g_perf
    logic [PERF_CNT_W-1:0] grant_cnt_r;

    // Count accept pulses for this channel
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        grant_cnt_r <= '0;
      end else if (req_ready[g]) begin
        grant_cnt_r <= sat_inc(grant_cnt_r);
      end else begin
        grant_cnt_r <= grant_cnt_r;
      end
    end

    assign perf_grants[g*PERF_CNT_W +: PERF_CNT_W] = grant_cnt_r;
  end
`endif

endmodule
